jy61p_cfg_seq: RTL and testbench
================================

// Module: jy61p_cfg_seq
// PURPOSE
//  Configuration sequencer for the JY61P IMU that feeds the gyro APB peripheral.
//  On a start pulse it sends three frames to the sensor RX pin: unlock, one
//  register write, and optionally save. Each frame is 5 bytes of 8N1 UART
//  (TX only).
//  Sits beside the JY61P receive path. Typical uses: set output rate or bandwidth
//  at boot, or rezero yaw at run time.
// PARAMETERS
//  CLK_FREQ  50_000_000  clk frequency, Hz
//  BAUD      9600        UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer, >=2)
//  GAP_CYC   50_000      idle-high cycles between frames (>=1)
// PORTS
//  clk       in   1   system clock, single domain
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   1-cycle request; sampled only in IDLE
//  reg_addr  in   8   JY61P register address, latched at accepted start
//  reg_data  in   16  register value, latched at accepted start
//  abort     in   1   stop the sequence at the next byte boundary
//  busy      out  1   high from the cycle after accepted start until DONE/ABORTED exit
//  done      out  1   1-cycle pulse when the whole sequence has been sent
//  aborted   out  1   1-cycle pulse when an abort has been honoured
//  uart_tx   out  1   serial line to sensor, idle high
// BEHAVIOUR
//  Reset (async, rst=1): busy=0, done=0, aborted=0, uart_tx=1, FSM=IDLE.
//    All counters clear.
//    Reset asserted mid-byte truncates the byte; the line returns high immediately.
//  Frames (bytes sent in order):
//    UNLOCK: FF AA 69 88 B5
//    WRITE:  FF AA reg_addr reg_data[7:0] reg_data[15:8]
//    SAVE:   FF AA 00 00 00
//  Byte serializer: start bit 0, then d[0]..d[7] LSB first, then stop bit 1.
//    Each bit lasts exactly BAUD_DIV cycles, so one byte = 10*BAUD_DIV cycles.
//    Bytes within a frame are back-to-back, with no extra idle.
//  FSM: IDLE -> TX_UNLOCK -> GAP1 -> TX_WRITE -> [GAP2 -> TX_SAVE] -> DONE -> IDLE.
//    Abort path: any TX_*/GAP* state -> ABORTED -> IDLE.
//  IDLE: uart_tx=1.
//    When start=1 on edge k, latch the inputs; the start bit begins at edge k+1.
//    busy rises at edge k+1.
//  GAPn: uart_tx=1 for exactly GAP_CYC cycles.
//  DONE and ABORTED each last 1 cycle and pulse their output.
//    busy falls in the same cycle the pulse is driven.
//  Pulse timing: done is driven in the cycle right after the last stop bit's
//    final cycle.
//  start while busy=1: ignored, not queued; the latched addr/data are unchanged.
//  start and abort together in IDLE: start wins, abort is ignored.
//  abort while in TX_*: the current byte, including its stop bit, completes.
//    Next state is ABORTED, so the line is never left low.
//  abort while in GAPn: ABORTED on the next cycle.
//  abort is a level. It is sampled each cycle and honoured at the first eligible
//    point.
//  Back-to-back: start in the cycle after done is accepted. The line stays high
//    at least 1 cycle between sequences.
// CONFIGURATION
//  JY61P_CFG_SAVE_EN defined:
//    GAP2 and SAVE frames are sent, 15 bytes total.
//    done rises at 15*10*BAUD_DIV + 2*GAP_CYC + 1 cycles after the start edge.
//  JY61P_CFG_SAVE_EN undefined:
//    GAP2 and TX_SAVE are not built; TX_WRITE -> DONE. 10 bytes total.
//    done rises at 100*BAUD_DIV + GAP_CYC + 1 cycles after the start edge.
// TESTING  (bench params: CLK_FREQ=1000, BAUD=100 -> BAUD_DIV=10, GAP_CYC=20)
//  1 rst=1 at time 0 -> uart_tx=1, busy=0, done=0, aborted=0 until first start.
//  2 start pulse, reg_addr=0x03, reg_data=0x0008, SAVE_EN defined.
//    -> UART monitor decodes FF AA 69 88 B5 | FF AA 03 08 00 | FF AA 00 00 00.
//    -> each bit is 10 cycles; each gap is 20 cycles high.
//    -> done pulses once at start edge +1541; busy is high for exactly that span.
//  3 Same stimulus, SAVE_EN undefined.
//    -> only the first 10 bytes are sent; done pulses at +1021.
//  4 start again at +5 while busy, with reg_addr=0x55.
//    -> ignored; the WRITE frame still carries 0x03; only one done pulse.
//  5a abort during byte 2 bit 3 -> byte 2 completes with its stop bit.
//    -> aborted pulses at the cycle after that stop bit; done never pulses;
//       uart_tx=1.
//  5b abort during GAP1 -> aborted on the next cycle.
//  6 rst pulse mid-byte -> uart_tx=1 and busy=0 asynchronously.
//    -> a new start afterwards yields a clean full sequence.

Source files
------------

// File: rtl/jy61p_cfg_seq.sv
// JY61P configuration sequencer: sends unlock, register-write and optional save frames as 8N1 UART bytes.
// Define JY61P_CFG_SAVE_EN to build the GAP2 + SAVE frame; otherwise the sequence ends after the write frame.
module jy61p_cfg_seq #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned GAP_CYC  = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] reg_data,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        uart_tx
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned DIV_W    = $clog2(BAUD_DIV);
  localparam int unsigned GAP_W    = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    TX_UNLOCK,
    GAP1,
    TX_WRITE,
`ifdef JY61P_CFG_SAVE_EN
    GAP2,
    TX_SAVE,
`endif
    DONE,
    ABORTED
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              abort_pend_q, abort_pend_d;
  logic [7:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              tx_c, busy_c, done_c, aborted_c;
  logic              is_tx, is_gap;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_idx;
  logic              tx_bit;
  state_t            gap_next, tx_next;

  // Frame byte currently being serialized and the line level for the current bit slot
  always_comb begin
    cur_byte = 8'h00;
    bit_idx  = 3'(bit_q - 4'd1);
    if (byte_q == 3'd0) begin
      cur_byte = 8'hFF;
    end else if (byte_q == 3'd1) begin
      cur_byte = 8'hAA;
    end else if (state_q == TX_UNLOCK) begin
      cur_byte = (byte_q == 3'd2) ? 8'h69 : (byte_q == 3'd3) ? 8'h88 : 8'hB5;
    end else if (state_q == TX_WRITE) begin
      cur_byte = (byte_q == 3'd2) ? addr_q : (byte_q == 3'd3) ? data_q[7:0] : data_q[15:8];
    end
    if (bit_q == 4'd0) begin
      tx_bit = 1'b0;
    end else if (bit_q == 4'd9) begin
      tx_bit = 1'b1;
    end else begin
      tx_bit = cur_byte[bit_idx];
    end
  end

  // State classification and successor states
  always_comb begin
`ifdef JY61P_CFG_SAVE_EN
    is_tx    = (state_q == TX_UNLOCK) || (state_q == TX_WRITE) || (state_q == TX_SAVE);
    is_gap   = (state_q == GAP1) || (state_q == GAP2);
    gap_next = (state_q == GAP2) ? TX_SAVE : TX_WRITE;
    tx_next  = (state_q == TX_UNLOCK) ? GAP1 : (state_q == TX_WRITE) ? GAP2 : DONE;
`else
    is_tx    = (state_q == TX_UNLOCK) || (state_q == TX_WRITE);
    is_gap   = (state_q == GAP1);
    gap_next = TX_WRITE;
    tx_next  = (state_q == TX_UNLOCK) ? GAP1 : DONE;
`endif
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    gap_d        = gap_q;
    abort_pend_d = abort_pend_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tx_c         = 1'b1;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    aborted_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = TX_UNLOCK;
          addr_d       = reg_addr;
          data_d       = reg_data;
          div_d        = '0;
          bit_d        = '0;
          byte_d       = '0;
          gap_d        = '0;
          abort_pend_d = 1'b0;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      ABORTED: begin
        aborted_c = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        if (is_gap) begin
          busy_c = 1'b1;
          if (abort) begin
            state_d = ABORTED;
          end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            gap_d   = '0;
            state_d = gap_next;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else if (is_tx) begin
          busy_c = 1'b1;
          tx_c   = tx_bit;
          if (abort) abort_pend_d = 1'b1;
          // Abort is only honoured once the stop bit has fully gone out
          if (div_q == DIV_W'(BAUD_DIV - 1)) begin
            div_d = '0;
            if (bit_q == 4'd9) begin
              bit_d = '0;
              if (abort || abort_pend_q) begin
                state_d = ABORTED;
              end else if (byte_q == 3'd4) begin
                byte_d  = '0;
                gap_d   = '0;
                state_d = tx_next;
              end else begin
                byte_d = byte_q + 3'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, counters, latched payload and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      gap_q        <= '0;
      abort_pend_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      gap_q        <= gap_d;
      abort_pend_q <= abort_pend_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      uart_tx      <= tx_c;
      busy         <= busy_c;
      done         <= done_c;
      aborted      <= aborted_c;
    end
  end

endmodule

// File: tb/tb_jy61p_cfg_seq.sv
// Scoreboard bench for jy61p_cfg_seq: a UART monitor pops expected bytes; scenario tasks check pulses, busy span and timing.
// Follows JY61P_CFG_SAVE_EN the same way as the design.
module tb_jy61p_cfg_seq;

  localparam int DIV = 10;
  localparam int GAP = 20;
  localparam int BYTE_CYC  = 10 * DIV;
  localparam int FRAME_CYC = 5 * BYTE_CYC + GAP;
`ifdef JY61P_CFG_SAVE_EN
  localparam int NB     = 15;
  localparam int T_DONE = 15 * 10 * DIV + 2 * GAP + 1;
`else
  localparam int NB     = 10;
  localparam int T_DONE = 100 * DIV + GAP + 1;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         byte_t[$];

  logic [7:0] m_byte;
  logic [7:0] m_exp;
  logic       m_ok;
  logic       m_trunc;
  int         m_t0;

  jy61p_cfg_seq #(.CLK_FREQ(1000), .BAUD(100), .GAP_CYC(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .uart_tx  (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // UART receiver: samples every cycle of each bit, pops the scoreboard on each complete byte
  initial begin : uart_mon
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        m_t0 = cyc; m_ok = 1'b1; m_trunc = 1'b0; m_byte = '0;
        for (int i = 1; i < 10; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) m_trunc = 1'b1;
          if (uart_tx !== 1'b0) m_ok = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rst !== 1'b0) m_trunc = 1'b1;
            if (i == 0) m_byte[k] = uart_tx;
            else if (uart_tx !== m_byte[k]) m_ok = 1'b0;
          end
        end
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) m_trunc = 1'b1;
          if (uart_tx !== 1'b1) m_ok = 1'b0;
        end
        if (!m_trunc) begin
          byte_t.push_back(m_t0);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL uart_byte: got %02h at cycle %0d, required no byte", m_byte, m_t0);
          end else begin
            m_exp = exp_q.pop_front();
            if (m_byte !== m_exp) begin
              errors++;
              $display("FAIL uart_byte: got %02h at cycle %0d, required %02h", m_byte, m_t0, m_exp);
            end
          end
          checks++;
          if (m_ok !== 1'b1) begin
            errors++;
            $display("FAIL uart_frame: byte at cycle %0d framing/bit width ok=%0b, required 1", m_t0, m_ok);
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] a, input logic [15:0] d);
    int f = i / 5;
    int j = i % 5;
    logic [7:0] b;
    if (j == 0) b = 8'hFF;
    else if (j == 1) b = 8'hAA;
    else if (f == 0) b = (j == 2) ? 8'h69 : (j == 3) ? 8'h88 : 8'hB5;
    else if (f == 1) b = (j == 2) ? a : (j == 3) ? d[7:0] : d[15:8];
    else b = 8'h00;
    return b;
  endfunction

  // Push the expected bytes and raise start; ks is the edge that samples it
  task automatic launch(input logic [7:0] a, input logic [15:0] d, input bit b2b, input int nbytes, output int ks);
    if (!b2b) @(negedge clk);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(exp_byte(i, a, d));
    reg_addr = a;
    reg_data = d;
    start    = 1'b1;
    ks       = cyc + 1;
  endtask

  // Run until done/aborted (+tail cycles) collecting observations; optional start poke and abort
  task automatic observe(input int ks, input int limit, input int poke_at, input int abort_at, input int tail,
                         output int e, output int nd, output int na, output int bf, output int bl,
                         output int bc, output int hb);
    e = -1; nd = 0; na = 0; bf = -1; bl = -1; bc = 0; hb = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (cyc == ks + poke_at) begin
        start = 1'b1; reg_addr = 8'h55; reg_data = 16'hBEEF;
      end else begin
        start = 1'b0;
      end
      if (cyc == ks + abort_at) abort = 1'b1;
      if (busy === 1'b1) begin
        if (bf < 0) bf = cyc;
        bl = cyc;
        bc++;
      end
      if (done === 1'b1) begin nd++; if (e < 0) e = cyc; end
      if (aborted === 1'b1) begin na++; if (e < 0) e = cyc; abort = 1'b0; end
      if (e >= 0 && uart_tx !== 1'b1) hb++;
      if (e >= 0 && cyc >= e + tail) break;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b, required 1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b, required 0", aborted); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b done=%b, required 1 0 0", uart_tx, busy, done);
    end
  endtask

  task automatic test_full_seq(input logic [7:0] a, input logic [15:0] d);
    int ks, e, nd, na, bf, bl, bc, hb, tbad;
    byte_t.delete();
    launch(a, d, 1'b0, NB, ks);
    observe(ks, T_DONE + 60, -1, -1, 30, e, nd, na, bf, bl, bc, hb);
    checks++; if (e !== ks + T_DONE) begin errors++; $display("FAIL full_done_time: got %0d, required %0d (-1 = timeout)", e, ks + T_DONE); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL full_done_count: got %0d, required 1", nd); end
    checks++; if (na !== 0) begin errors++; $display("FAIL full_aborted_count: got %0d, required 0", na); end
    checks++;
    if (bf !== ks + 1 || bl !== ks + T_DONE - 1 || bc !== T_DONE - 1) begin
      errors++;
      $display("FAIL full_busy_span: first=%0d last=%0d n=%0d, required %0d %0d %0d", bf, bl, bc, ks + 1, ks + T_DONE - 1, T_DONE - 1);
    end
    checks++; if (hb !== 0) begin errors++; $display("FAIL full_line_idle: %0d low cycles after done, required 0", hb); end
    tbad = (byte_t.size() == NB) ? 0 : 1;
    for (int i = 0; i < byte_t.size() && i < NB; i++)
      if (byte_t[i] != ks + 1 + (i / 5) * FRAME_CYC + (i % 5) * BYTE_CYC) tbad++;
    checks++; if (tbad !== 0) begin errors++; $display("FAIL full_byte_timing: %0d bad (bytes seen %0d), required 0 bad of %0d", tbad, byte_t.size(), NB); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL full_bytes_left: got %0d unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_ignore_start();
    int ks, e, nd, na, bf, bl, bc, hb;
    launch(8'h03, 16'h0008, 1'b0, NB, ks);
    observe(ks, T_DONE + 60, 4, -1, 30, e, nd, na, bf, bl, bc, hb);
    checks++; if (e !== ks + T_DONE) begin errors++; $display("FAIL ignore_done_time: got %0d, required %0d", e, ks + T_DONE); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", nd); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ignore_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ks, e, nd, na, bf, bl, bc, hb, ks2, e2;
    launch(8'h1F, 16'hA5C3, 1'b0, NB, ks);
    observe(ks, T_DONE + 60, -1, -1, 0, e, nd, na, bf, bl, bc, hb);
    checks++; if (e !== ks + T_DONE) begin errors++; $display("FAIL b2b_first_done: got %0d, required %0d", e, ks + T_DONE); end
    byte_t.delete();
    launch(8'h62, 16'h7E01, 1'b1, NB, ks2);
    observe(ks2, T_DONE + 60, -1, -1, 30, e2, nd, na, bf, bl, bc, hb);
    checks++; if (e2 !== e + 1 + T_DONE) begin errors++; $display("FAIL b2b_second_done: got %0d, required %0d", e2, e + 1 + T_DONE); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d, required 1", nd); end
    checks++;
    if (byte_t.size() == 0 || byte_t[0] != e + 2) begin
      errors++;
      $display("FAIL b2b_first_byte: got %0d bytes, first at %0d, required first at %0d", byte_t.size(), (byte_t.size() > 0) ? byte_t[0] : -1, e + 2);
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_abort_tx();
    int ks, e, nd, na, bf, bl, bc, hb;
    byte_t.delete();
    launch(8'h03, 16'h0008, 1'b0, 2, ks);
    observe(ks, 400, -1, BYTE_CYC + 34, 30, e, nd, na, bf, bl, bc, hb);
    checks++; if (e !== ks + 2 * BYTE_CYC + 1) begin errors++; $display("FAIL abort_tx_time: got %0d, required %0d", e, ks + 2 * BYTE_CYC + 1); end
    checks++; if (na !== 1 || nd !== 0) begin errors++; $display("FAIL abort_tx_pulses: aborted=%0d done=%0d, required 1 0", na, nd); end
    checks++; if (bl !== ks + 2 * BYTE_CYC) begin errors++; $display("FAIL abort_tx_busy_fall: last busy %0d, required %0d", bl, ks + 2 * BYTE_CYC); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL abort_tx_line: %0d low cycles, required 0", hb); end
    checks++; if (exp_q.size() !== 0 || byte_t.size() !== 2) begin errors++; $display("FAIL abort_tx_bytes: left=%0d seen=%0d, required 0 2", exp_q.size(), byte_t.size()); end
  endtask

  task automatic test_abort_gap();
    int ks, e, nd, na, bf, bl, bc, hb;
    byte_t.delete();
    launch(8'h03, 16'h0008, 1'b0, 5, ks);
    observe(ks, 800, -1, 5 * BYTE_CYC + 5, 30, e, nd, na, bf, bl, bc, hb);
    checks++; if (e !== ks + 5 * BYTE_CYC + 7) begin errors++; $display("FAIL abort_gap_time: got %0d, required %0d", e, ks + 5 * BYTE_CYC + 7); end
    checks++; if (na !== 1 || nd !== 0) begin errors++; $display("FAIL abort_gap_pulses: aborted=%0d done=%0d, required 1 0", na, nd); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL abort_gap_line: %0d low cycles, required 0", hb); end
    checks++; if (exp_q.size() !== 0 || byte_t.size() !== 5) begin errors++; $display("FAIL abort_gap_bytes: left=%0d seen=%0d, required 0 5", exp_q.size(), byte_t.size()); end
  endtask

  task automatic test_reset_mid();
    int ks;
    launch(8'h03, 16'h0008, 1'b0, NB, ks);
    // byte 2 (0x69) data bit 1 is a 0, so the line is low here
    while (cyc < ks + 2 * BYTE_CYC + 25) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midbyte_line_low: got %b, required 0", uart_tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b, required 1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b, required 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    exp_q.delete();
    checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: tx=%b busy=%b, required 1 0", uart_tx, busy); end
    test_full_seq(8'h03, 16'h0008);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; reg_addr = '0; reg_data = '0;
    test_reset();
    test_full_seq(8'h03, 16'h0008);
    test_ignore_start();
    test_back_to_back();
    test_abort_tx();
    test_abort_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
